// File: rtl/arf086b128e1r1w0cbbehsaa4acw_wr_sched_if.sv
// Write-request handshake bundle for the 128x86 1R1W latch-array write scheduler.
// master: request source. slave: the scheduler.
interface arf086b128e1r1w0cbbehsaa4acw_wr_sched_if #(
    parameter int unsigned AWIDTH = 7,
    parameter int unsigned DWIDTH = 86
) ();
    logic              wr_vld;
    logic              wr_rdy;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;

    modport master (
        output wr_vld,
        output wr_addr,
        output wr_data,
        input  wr_rdy
    );

    modport slave (
        input  wr_vld,
        input  wr_addr,
        input  wr_data,
        output wr_rdy
    );
endinterface

// File: rtl/arf086b128e1r1w0cbbehsaa4acw_wr_sched.sv
// Write-port scheduler for the 128-entry x 86-bit 1R1W latch array.
// Incoming writes go through a small circular queue. At most one registered
// write per cycle is issued to the array's phase-B data/wordline latches.
// The head write is deferred while the same-cycle read targets its row, and
// while arr_hold is high.
// Optional read bypass: define ARF086B128E1R1W0CBBEHSAA4ACW_WR_BYPASS_EN to
// forward pending and in-flight write data to the read port. Without it,
// rd_hit and rd_byp_data are tied to zero.
module arf086b128e1r1w0cbbehsaa4acw_wr_sched #(
    parameter int unsigned DWIDTH = 86,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned AWIDTH = 7,
    parameter int unsigned QDEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    arf086b128e1r1w0cbbehsaa4acw_wr_sched_if.slave wr,
    input  logic                          rd_en,
    input  logic [AWIDTH-1:0]             rd_addr,
    input  logic                          arr_hold,
    output logic                          arr_wr_en,
    output logic [DEPTH-1:0]              arr_wr_wl,
    output logic [DWIDTH-1:0]             arr_wr_data,
    output logic                          rd_hit,
    output logic [DWIDTH-1:0]             rd_byp_data,
    output logic [$clog2(QDEPTH):0]       pend_cnt,
    output logic                          idle
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    // Queue storage. It is not reset: only entries below count are ever read.
    logic [AWIDTH-1:0] q_addr [QDEPTH];
    logic [DWIDTH-1:0] q_data [QDEPTH];

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic              rdy_q;

    logic              push;
    logic              pop;
    logic [AWIDTH-1:0] head_addr;
    logic [DWIDTH-1:0] head_data;
    logic              head_conflict;
    logic [DEPTH-1:0]  wl_nxt;

    // wr_rdy comes straight from a flop, so issue has no combinational path to it.
    assign wr.wr_rdy     = rdy_q;
    assign push          = wr.wr_vld & rdy_q;

    assign head_addr     = q_addr[rd_ptr];
    assign head_data     = q_data[rd_ptr];
    assign head_conflict = rd_en & (rd_addr == head_addr);
    assign pop           = (count != '0) & ~arr_hold & ~head_conflict;

    assign pend_cnt      = count;
    assign idle          = (count == '0) & ~arr_wr_en;

    // Next occupancy; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // One-hot wordline for the head entry's row.
    always_comb begin
        wl_nxt            = '0;
        wl_nxt[head_addr] = 1'b1;
    end

    // Capture accepted requests into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= wr.wr_addr;
            q_data[wr_ptr] <= wr.wr_data;
        end
    end

    // Queue pointers, occupancy and registered ready.
    // QDEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_nxt;
            rdy_q <= (count_nxt < CW'(QDEPTH));
        end
    end

    // Registered array write port. Data is held between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_wr_en   <= 1'b0;
            arr_wr_wl   <= '0;
            arr_wr_data <= '0;
        end else begin
            arr_wr_en <= pop;
            arr_wr_wl <= pop ? wl_nxt : '0;
            if (pop) begin
                arr_wr_data <= head_data;
            end
        end
    end

`ifdef ARF086B128E1R1W0CBBEHSAA4ACW_WR_BYPASS_EN
    logic [AWIDTH-1:0] infl_addr;
    logic [PW-1:0]     scan_idx;
    logic              any_hit;
    logic [DWIDTH-1:0] hit_data;

    // Row address of the write currently on the array port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_addr <= '0;
        end else if (pop) begin
            infl_addr <= head_addr;
        end
    end

    // Youngest matching write wins. The in-flight write is checked first,
    // then queue entries from oldest to newest, so a later match overrides
    // an earlier one.
    always_comb begin
        any_hit  = 1'b0;
        hit_data = '0;
        scan_idx = '0;
        if (arr_wr_en && (infl_addr == rd_addr)) begin
            any_hit  = 1'b1;
            hit_data = arr_wr_data;
        end
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            scan_idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && (q_addr[scan_idx] == rd_addr)) begin
                any_hit  = 1'b1;
                hit_data = q_data[scan_idx];
            end
        end
        rd_hit      = rd_en & any_hit;
        rd_byp_data = (rd_en & any_hit) ? hit_data : '0;
    end
`else
    assign rd_hit      = 1'b0;
    assign rd_byp_data = '0;
`endif

endmodule

// File: tb/tb_arf086b128e1r1w0cbbehsaa4acw_wr_sched.sv
// Directed self-checking bench for the latch-array write scheduler.
// Inputs change 1 time unit after the rising edge. Registered outputs are
// checked at that same point, so each step() covers exactly one edge.
module tb_arf086b128e1r1w0cbbehsaa4acw_wr_sched;

    localparam int unsigned DW = 86;
    localparam int unsigned DP = 128;
    localparam int unsigned AW = 7;
    localparam int unsigned QD = 2;
`ifdef ARF086B128E1R1W0CBBEHSAA4ACW_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          arr_hold;
    logic          arr_wr_en;
    logic [DP-1:0] arr_wr_wl;
    logic [DW-1:0] arr_wr_data;
    logic          rd_hit;
    logic [DW-1:0] rd_byp_data;
    logic [1:0]    pend_cnt;
    logic          idle;

    int n_tests;
    int n_fail;

    arf086b128e1r1w0cbbehsaa4acw_wr_sched_if #(.AWIDTH(AW), .DWIDTH(DW)) wr_bus ();

    arf086b128e1r1w0cbbehsaa4acw_wr_sched #(
        .DWIDTH(DW),
        .DEPTH (DP),
        .AWIDTH(AW),
        .QDEPTH(QD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr         (wr_bus),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .arr_hold   (arr_hold),
        .arr_wr_en  (arr_wr_en),
        .arr_wr_wl  (arr_wr_wl),
        .arr_wr_data(arr_wr_data),
        .rd_hit     (rd_hit),
        .rd_byp_data(rd_byp_data),
        .pend_cnt   (pend_cnt),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] onehot(input int unsigned a);
        logic [127:0] v;
        v = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_en"},   arr_wr_en,   0);
        chk({tag, "_wl"},   arr_wr_wl,   0);
        chk({tag, "_data"}, arr_wr_data, 0);
        chk({tag, "_pend"}, pend_cnt,    0);
        chk({tag, "_rdy"},  wr_bus.wr_rdy, 0);
        chk({tag, "_idle"}, idle,        1);
        chk({tag, "_hit"},  rd_hit,      0);
        chk({tag, "_byp"},  rd_byp_data, 0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n          = 1'b0;
        rd_en          = 1'b0;
        rd_addr        = '0;
        arr_hold       = 1'b0;
        wr_bus.wr_vld  = 1'b0;
        wr_bus.wr_addr = '0;
        wr_bus.wr_data = '0;

        // ---- reset state
        step();
        step();
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        step();
        chk("rel_rdy",  wr_bus.wr_rdy, 1);
        chk("rel_idle", idle, 1);

        // ---- single write addr 7 data 0x15
        wr_bus.wr_vld  = 1'b1;
        wr_bus.wr_addr = 7'd7;
        wr_bus.wr_data = 86'h15;
        step();
        chk("t1_acc_pend", pend_cnt, 1);
        chk("t1_acc_en",   arr_wr_en, 0);
        chk("t1_acc_idle", idle, 0);
        wr_bus.wr_vld = 1'b0;
        step();
        chk("t1_en",   arr_wr_en, 1);
        chk("t1_wl",   arr_wr_wl, onehot(7));
        chk("t1_data", arr_wr_data, 128'h15);
        chk("t1_pend", pend_cnt, 0);
        step();
        chk("t1_en_off", arr_wr_en, 0);
        chk("t1_wl_off", arr_wr_wl, 0);
        chk("t1_held",   arr_wr_data, 128'h15);
        chk("t1_idle",   idle, 1);

        // ---- back-to-back writes to rows 1..4
        wr_bus.wr_vld = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wr_bus.wr_addr = AW'(i);
            wr_bus.wr_data = DW'(32'h100 + i);
            step();
            chk("t2_pend", pend_cnt, 1);
            chk("t2_rdy",  wr_bus.wr_rdy, 1);
            if (i > 1) begin
                chk("t2_en",   arr_wr_en, 1);
                chk("t2_wl",   arr_wr_wl, onehot(i - 1));
                chk("t2_data", arr_wr_data, 128'h100 + 128'(i - 1));
            end else begin
                chk("t2_first_en", arr_wr_en, 0);
            end
        end
        wr_bus.wr_vld = 1'b0;
        step();
        chk("t2_last_en",   arr_wr_en, 1);
        chk("t2_last_wl",   arr_wr_wl, onehot(4));
        chk("t2_last_data", arr_wr_data, 128'h104);
        chk("t2_last_pend", pend_cnt, 0);
        step();
        chk("t2_done_idle", idle, 1);

        // ---- read conflict on head row 5 for 3 cycles
        rd_en          = 1'b1;
        rd_addr        = 7'd5;
        wr_bus.wr_vld  = 1'b1;
        wr_bus.wr_addr = 7'd5;
        wr_bus.wr_data = 86'h55;
        step();
        chk("t3_pend1", pend_cnt, 1);
        wr_bus.wr_addr = 7'd9;
        wr_bus.wr_data = 86'h99;
        step();
        wr_bus.wr_vld = 1'b0;
        chk("t3_pend2", pend_cnt, 2);
        chk("t3_rdy0",  wr_bus.wr_rdy, 0);
        chk("t3_en0",   arr_wr_en, 0);
        chk("t3_hit",   rd_hit, BYP ? 1 : 0);
        chk("t3_byp",   rd_byp_data, BYP ? 128'h55 : 128'h0);
        step();
        chk("t3_hold_pend", pend_cnt, 2);
        chk("t3_hold_en",   arr_wr_en, 0);
        step();
        chk("t3_hold2_pend", pend_cnt, 2);
        chk("t3_hold2_en",   arr_wr_en, 0);
        chk("t3_hold2_rdy",  wr_bus.wr_rdy, 0);
        rd_en = 1'b0;
        step();
        chk("t3_i5_en",   arr_wr_en, 1);
        chk("t3_i5_wl",   arr_wr_wl, onehot(5));
        chk("t3_i5_data", arr_wr_data, 128'h55);
        chk("t3_i5_pend", pend_cnt, 1);
        chk("t3_i5_rdy",  wr_bus.wr_rdy, 1);
        step();
        chk("t3_i9_en",   arr_wr_en, 1);
        chk("t3_i9_wl",   arr_wr_wl, onehot(9));
        chk("t3_i9_data", arr_wr_data, 128'h99);
        chk("t3_i9_pend", pend_cnt, 0);
        step();
        chk("t3_idle", idle, 1);

        // ---- arr_hold for 4 cycles with writes pending
        arr_hold       = 1'b1;
        wr_bus.wr_vld  = 1'b1;
        wr_bus.wr_addr = 7'd20;
        wr_bus.wr_data = 86'h20;
        step();
        wr_bus.wr_addr = 7'd21;
        wr_bus.wr_data = 86'h21;
        step();
        chk("t4_pend2", pend_cnt, 2);
        chk("t4_rdy0",  wr_bus.wr_rdy, 0);
        chk("t4_en0",   arr_wr_en, 0);
        wr_bus.wr_addr = 7'd22;
        wr_bus.wr_data = 86'h22;
        step();
        step();
        chk("t4_full_pend", pend_cnt, 2);
        chk("t4_full_en",   arr_wr_en, 0);
        arr_hold = 1'b0;
        step();
        chk("t4_d20_en",   arr_wr_en, 1);
        chk("t4_d20_wl",   arr_wr_wl, onehot(20));
        chk("t4_d20_pend", pend_cnt, 1);
        chk("t4_d20_rdy",  wr_bus.wr_rdy, 1);
        step();
        wr_bus.wr_vld = 1'b0;
        chk("t4_d21_wl",   arr_wr_wl, onehot(21));
        chk("t4_d21_data", arr_wr_data, 128'h21);
        chk("t4_d21_pend", pend_cnt, 1);
        step();
        chk("t4_d22_wl",   arr_wr_wl, onehot(22));
        chk("t4_d22_data", arr_wr_data, 128'h22);
        chk("t4_d22_pend", pend_cnt, 0);
        step();
        chk("t4_idle", idle, 1);
        chk("t4_rdy",  wr_bus.wr_rdy, 1);

        // ---- duplicate row 12: bypass must return the youngest data
        rd_en          = 1'b1;
        rd_addr        = 7'd12;
        wr_bus.wr_vld  = 1'b1;
        wr_bus.wr_addr = 7'd12;
        wr_bus.wr_data = 86'hAAA;
        step();
        chk("t5_hitA", rd_hit, BYP ? 1 : 0);
        chk("t5_bypA", rd_byp_data, BYP ? 128'hAAA : 128'h0);
        wr_bus.wr_data = 86'hBBB;
        step();
        wr_bus.wr_vld = 1'b0;
        chk("t5_pend2", pend_cnt, 2);
        chk("t5_hitB",  rd_hit, BYP ? 1 : 0);
        chk("t5_bypB",  rd_byp_data, BYP ? 128'hBBB : 128'h0);
        rd_en = 1'b0;
        step();
        chk("t5_iA_data", arr_wr_data, 128'hAAA);
        chk("t5_iA_pend", pend_cnt, 1);
        step();
        chk("t5_iB_data", arr_wr_data, 128'hBBB);
        chk("t5_iB_en",   arr_wr_en, 1);
        rd_en   = 1'b1;
        rd_addr = 7'd12;
        #1;
        chk("t5_infl_hit", rd_hit, BYP ? 1 : 0);
        chk("t5_infl_byp", rd_byp_data, BYP ? 128'hBBB : 128'h0);
        rd_addr = 7'd13;
        #1;
        chk("t5_miss_hit", rd_hit, 0);
        chk("t5_miss_byp", rd_byp_data, 0);
        rd_en = 1'b0;
        step();

        // ---- reset while writes are queued and one is in flight
        arr_hold       = 1'b1;
        wr_bus.wr_vld  = 1'b1;
        wr_bus.wr_addr = 7'd40;
        wr_bus.wr_data = 86'h40;
        step();
        wr_bus.wr_addr = 7'd41;
        wr_bus.wr_data = 86'h41;
        step();
        wr_bus.wr_vld = 1'b0;
        chk("t6_pend2", pend_cnt, 2);
        arr_hold = 1'b0;
        step();
        chk("t6_infl_en",   arr_wr_en, 1);
        chk("t6_infl_pend", pend_cnt, 1);
        rst_n   = 1'b0;
        rd_en   = 1'b1;
        rd_addr = 7'd41;
        #1;
        chk_reset_outputs("t6_rst");
        rd_en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("t6_rel_rdy", wr_bus.wr_rdy, 1);
        for (int i = 0; i < 3; i++) begin
            chk("t6_no_stale_en",   arr_wr_en, 0);
            chk("t6_no_stale_pend", pend_cnt, 0);
            step();
        end
        chk("t6_idle", idle, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arf086b128e1r1w0cbbehsaa4acw_wr_sched.md
Name: arf086b128e1r1w0cbbehsaa4acw_wr_sched

Overview:
Write-port scheduler for the 128-entry x 86-bit 1R1W latch array. It buffers incoming write requests in a 2-entry queue and issues one registered write per cycle to the array's phase-B data/wordline latches. A write is deferred when the same-cycle read targets the same row. When the optional bypass is compiled in, it also forwards pending write data to the read port.

Parameters:
DWIDTH, 86, data width of one array row
DEPTH, 128, number of array rows
AWIDTH, 7, row address width; must equal clog2(DEPTH)
QDEPTH, 2, write queue entries; legal values 2 or 4

Ports:
clk  in  1  array clock; rising edge is the only sampling edge
rst_n  in  1  asynchronous active-low reset
wr_vld  in  1  write request valid
wr_rdy  out  1  write request ready; transfer when wr_vld & wr_rdy at rising clk
wr_addr  in  AWIDTH  write row address
wr_data  in  DWIDTH  write data
rd_en  in  1  array read this cycle
rd_addr  in  AWIDTH  array read row address
arr_hold  in  1  power/test hold; blocks issue, queue keeps accepting
arr_wr_en  out  1  registered array write enable; array latches data while clk low
arr_wr_wl  out  DEPTH  registered one-hot wordline for arr_wr_en
arr_wr_data  out  DWIDTH  registered write data; held when arr_wr_en is 0
rd_hit  out  1  rd_addr matches a pending or in-flight write (bypass builds only)
rd_byp_data  out  DWIDTH  youngest matching write data (bypass builds only)
pend_cnt  out  clog2(QDEPTH)+1  queue occupancy
idle  out  1  queue empty and arr_wr_en low

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - arr_wr_en=0, arr_wr_wl=0, arr_wr_data=0.
  - pend_cnt=0, wr_rdy=0 while rst_n low; wr_rdy=1 from the first edge after release.
  - idle=1, rd_hit=0, rd_byp_data=0.
  - Reset mid-operation discards all queued writes and any in-flight write.
- Queue:
  - Circular FIFO with wr_ptr, rd_ptr and count.
  - wr_rdy = (count < QDEPTH), registered-equivalent; no combinational path from issue. When full, wr_rdy stays 0 in a cycle that also pops.
  - Push and pop in the same cycle leave count unchanged. Pointers wrap modulo QDEPTH.
- Issue condition, evaluated each cycle on the head entry: count>0 & ~arr_hold & ~(rd_en & rd_addr==head.addr).
  - If true: pop, and at the next rising edge arr_wr_en=1, arr_wr_wl=1<<head.addr, arr_wr_data=head.data.
  - Otherwise: arr_wr_en=0 next cycle, wr_wl=0, data held.
- Latency: request accepted at edge N into an empty queue with no conflict -> arr_wr_en high in cycle N+1 -> array row updated by end of cycle N+1. Throughput is 1 write/cycle sustained.
- Empty queue: no bypass of the queue; requests always pass through it.
- Ordering: writes issue strictly in acceptance order. Duplicate addresses are kept, not merged.
- Conflict deferral repeats for as long as the read keeps hitting head.addr. Non-head entries never issue out of order.
- arr_hold: issue stops the cycle after hold is sampled high. An in-flight write completes; queued entries are preserved.
- idle = (count==0) & ~arr_wr_en.

Optional Feature:
Macro: ARF086B128E1R1W0CBBEHSAA4ACW_WR_BYPASS_EN
- Defined:
  - rd_hit = rd_en & (match on any valid queue entry or on the in-flight arr_wr entry). Combinational.
  - rd_byp_data selects the youngest match, in priority order: newest queue entry > older queue entry > in-flight entry.
  - rd_byp_data = 0 when there is no hit.
- Not defined: rd_hit and rd_byp_data tied to 0; no compare logic generated.

Test Plan:
- Reset release, single write addr=7, data=0x15 -> arr_wr_en=1 with arr_wr_wl[7]=1 and arr_wr_data=0x15 exactly one cycle after acceptance; idle=1 one cycle later.
- Back-to-back writes to addrs 1,2,3,4 with wr_vld held high -> one arr_wr_en per cycle in order; pend_cnt never exceeds 1; wr_rdy stays 1.
- Queue of 2 (addr 5, then 9) with rd_en=1, rd_addr=5 held for 3 cycles -> no issue for 3 cycles; pend_cnt=2 and wr_rdy=0; release -> 5 then 9 issue on consecutive cycles.
- arr_hold=1 for 4 cycles with writes pending -> queue fills to 2, wr_rdy=0, arr_wr_en=0; hold drops -> drain in order and wr_rdy returns to 1.
- Bypass build: queue addr 12 data A, then addr 12 data B; rd_en=1, rd_addr=12 -> rd_hit=1, rd_byp_data=B. Non-bypass build, same stimulus -> rd_hit=0.
- Assert rst_n low while pend_cnt=2 and arr_wr_en=1 -> all outputs reach reset values immediately; after release no stale write issues.
